// File: rtl/sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_array_ctrl
// Purpose  : DEPTH x WIDTH behavioural SRAM array with its own access
//            sequencer. Every access walks PRECH -> ACCESS -> SENSE -> DONE
//            behind a valid/ready request port, so one op completes every
//            5 cycles.
// Ports    : clk, rst (async, active-high)
//            req_valid/req_ready/req_we/req_addr/req_wdata[/req_wmask]
//            rsp_valid/rsp_err/rsp_rdata
//            pch, wl_active  (phase probes)
// Options  : SRAM_WMASK_EN - adds req_wmask (one enable per byte);
//            WIDTH must then be a multiple of 8.
// Revision : 1.0 - initial release
// ============================================================================
module sram_array_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
`ifdef SRAM_WMASK_EN
  input  logic [WIDTH/8-1:0] req_wmask,
`endif
  output logic             rsp_valid,
  output logic             rsp_err,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             pch,
  output logic             wl_active
);

  // One bit wider than the address so addresses >= DEPTH compare correctly
  // even when DEPTH is an exact power of two.
  localparam logic [AW:0] DEPTH_EXT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRECH  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_SENSE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [WIDTH-1:0]   wdata_q, wdata_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
`ifdef SRAM_WMASK_EN
  logic [WIDTH/8-1:0] wmask_q, wmask_d;
`endif

  // Array contents are deliberately not reset.
  logic [WIDTH-1:0]   mem [DEPTH];

  logic               w_commit;
  logic [AW-1:0]      w_idx;

  // Out-of-range ops never touch the array: steer the index to word 0 and
  // gate the write/read with err_q instead.
  assign w_idx    = err_q ? '0 : addr_q;
  assign w_commit = (state_q == ST_ACCESS) && we_q && !err_q;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
`ifdef SRAM_WMASK_EN
    wmask_d   = wmask_q;
`endif
    req_ready = 1'b0;
    pch       = 1'b0;
    wl_active = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = ST_PRECH;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = ({1'b0, req_addr} >= DEPTH_EXT);
`ifdef SRAM_WMASK_EN
          wmask_d = req_wmask;
`endif
        end
      end
      ST_PRECH: begin
        pch     = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        wl_active = 1'b1;
        state_d   = ST_SENSE;
      end
      ST_SENSE: begin
        wl_active = 1'b1;
        state_d   = ST_DONE;
        // Write responses leave rsp_rdata untouched; bad reads return zero.
        if (!we_q) begin
          rdata_d = err_q ? '0 : mem[w_idx];
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef SRAM_WMASK_EN
      wmask_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef SRAM_WMASK_EN
      wmask_q <= wmask_d;
`endif
    end
  end

  // An async reset forces state_q to IDLE at once, so an op aborted before
  // the ACCESS-exit edge never reaches this commit.
  always_ff @(posedge clk) begin
    if (w_commit) begin
`ifdef SRAM_WMASK_EN
      for (int b = 0; b < WIDTH/8; b++) begin
        if (wmask_q[b]) begin
          mem[w_idx][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
`else
      mem[w_idx] <= wdata_q;
`endif
    end
  end

  assign rsp_rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_array_ctrl
// Purpose  : Self-checking bench for sram_array_ctrl (WIDTH=32, DEPTH=48).
//            Expected responses are queued at acceptance and popped when
//            rsp_valid appears; a bench-side memory model supplies read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_array_ctrl;

  localparam int W  = 32;
  localparam int D  = 48;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [W-1:0]  req_wdata = '0;
  logic [W/8-1:0] req_wmask = '1;
  logic          rsp_valid;
  logic          rsp_err;
  logic [W-1:0]  rsp_rdata;
  logic          pch;
  logic          wl_active;

  sram_array_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
`ifdef SRAM_WMASK_EN
    .req_wmask (req_wmask),
`endif
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_rdata (rsp_rdata),
    .pch       (pch),
    .wl_active (wl_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;
    logic [W/8-1:0] wmask;
    logic          err;
    logic [W-1:0]  rdata;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mdl [D];
  logic [W-1:0] last_rdata = '0;
  int           n_cmp = 0;
  int           n_err = 0;

  function automatic logic [W-1:0] merge(input logic [W-1:0] old_v,
                                         input logic [W-1:0] new_v,
                                         input logic [W/8-1:0] m);
    logic [W-1:0] r;
    r = old_v;
`ifdef SRAM_WMASK_EN
    for (int b = 0; b < W/8; b++) if (m[b]) r[8*b +: 8] = new_v[8*b +: 8];
`else
    r = new_v;
    if (m == '0) r = new_v;
`endif
    return r;
  endfunction

  // Drive a request at a falling edge and return just after the accept edge.
  task automatic accept_req(input logic we, input logic [AW-1:0] addr,
                            input logic [W-1:0] wd, input logic [W/8-1:0] m);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wmask = m;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL accept_ready: got %b want 1", req_ready);
    end
    @(posedge clk); #1;
  endtask

  function automatic exp_t make_exp(input logic we, input logic [AW-1:0] addr,
                                    input logic [W-1:0] wd, input logic [W/8-1:0] m);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wd; e.wmask = m;
    e.err = (int'(addr) >= D);
    if (we)         e.rdata = last_rdata;
    else if (e.err) e.rdata = '0;
    else            e.rdata = mdl[addr];
    return e;
  endfunction

  // Full op through the scoreboard. While busy the request lines are
  // scrambled with req_valid held high; none of that may influence the op.
  task automatic run_op(input logic we, input logic [AW-1:0] addr,
                        input logic [W-1:0] wd, input logic [W/8-1:0] m);
    exp_t e;
    int   lat;
    accept_req(we, addr, wd, m);
    exp_q.push_back(make_exp(we, addr, wd, m));
    req_we = 1'($urandom); req_addr = AW'($urandom_range(0, D-1)); req_wdata = $urandom;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin lat = i; break; end
      req_we = 1'($urandom); req_addr = AW'($urandom_range(0, D-1)); req_wdata = $urandom;
    end
    req_valid = 1'b0;
    e = exp_q.pop_front();
    n_cmp++;
    if (lat != 4) begin
      n_err++; $display("FAIL latency addr=%0d: got %0d edges want 4", addr, lat);
    end
    if (lat != 0) begin
      n_cmp++;
      if (rsp_err !== e.err) begin
        n_err++; $display("FAIL rsp_err addr=%0d we=%b: got %b want %b", addr, we, rsp_err, e.err);
      end
      n_cmp++;
      if (rsp_rdata !== e.rdata) begin
        n_err++; $display("FAIL rsp_rdata addr=%0d we=%b: got %h want %h", addr, we, rsp_rdata, e.rdata);
      end
    end
    if (e.we && !e.err) mdl[e.addr] = merge(mdl[e.addr], e.wdata, e.wmask);
    if (!e.we) last_rdata = e.rdata;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_err++; $display("FAIL pulse_end: got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, pch, wl_active} !== 5'b10000 || rsp_rdata !== '0) begin
      n_err++;
      $display("FAIL %s: got rdy=%b v=%b e=%b pch=%b wl=%b rd=%h want 1/0/0/0/0/0",
               tag, req_ready, rsp_valid, rsp_err, pch, wl_active, rsp_rdata);
    end
  endtask

  task automatic test_reset();
    #1;
    check_reset_outputs("reset_init");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < D; a++) run_op(1'b1, AW'(a), $urandom, '1);
  endtask

  task automatic test_write_read();
    run_op(1'b1, 6'd5, 32'hDEADBEEF, '1);
    run_op(1'b0, 6'd5, '0, '1);
    n_cmp++;
    if (last_rdata !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL wr_rd_const: got %h want deadbeef", last_rdata);
    end
    run_op(1'b1, 6'd0, 32'h0000_0000, '1);
    run_op(1'b1, 6'd47, 32'hA5A5_5A5A, '1);
    run_op(1'b0, 6'd47, '0, '1);
    run_op(1'b1, 6'd1, 32'h1234_5678, '1);   // write response keeps last read data
    run_op(1'b0, 6'd0, '0, '1);
    run_op(1'b0, 6'd1, '0, '1);
  endtask

  task automatic test_phase();
    logic [3:0] p, w, v, r;
    accept_req(1'b0, 6'd5, '0, '1);
    exp_q.push_back(make_exp(1'b0, 6'd5, '0, '1));
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p[i] = pch; w[i] = wl_active; v[i] = rsp_valid; r[i] = req_ready;
    end
    n_cmp++;
    if (p !== 4'b0001 || w !== 4'b0110 || v !== 4'b1000 || r !== 4'b0000) begin
      n_err++; $display("FAIL phase: got pch=%b wl=%b v=%b rdy=%b want 0001/0110/1000/0000 (lsb first)",
                        p, w, v, r);
    end
    begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_err++; $display("FAIL phase_data: got %h/%b want %h/%b", rsp_rdata, rsp_err, e.rdata, e.err);
      end
      last_rdata = e.rdata;
    end
    @(negedge clk);
  endtask

  task automatic test_out_of_range();
    run_op(1'b1, 6'd2, 32'h0BAD_F00D, '1);
    run_op(1'b1, 6'd18, 32'hCAFE_0018, '1);
    run_op(1'b1, 6'd50, 32'h0000_0001, '1);
    run_op(1'b0, 6'd50, '0, '1);
    run_op(1'b0, 6'd48, '0, '1);
    run_op(1'b0, 6'd2, '0, '1);
    run_op(1'b0, 6'd18, '0, '1);
    run_op(1'b0, 6'd47, '0, '1);
  endtask

  // Abort a write after 'phase' falling edges (1=PRECH, 3=SENSE).
  task automatic test_abort(input int phase, input logic [AW-1:0] addr,
                            input logic [W-1:0] wd, input logic commits);
    accept_req(1'b1, addr, wd, '1);
    req_valid = 1'b0;
    repeat (phase) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort_reset_vals");
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    if (commits) mdl[addr] = wd;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin
        n_err++; $display("FAIL abort_no_rsp phase=%0d: got rsp_valid=%b want 0", phase, rsp_valid);
      end
    end
    run_op(1'b0, addr, '0, '1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 20; k++)
      run_op(1'($urandom), AW'($urandom_range(0, D-1)), $urandom, W/8'($urandom));
  endtask

  task automatic test_wmask();
    run_op(1'b1, 6'd9, 32'hFFFF_FFFF, '1);
    run_op(1'b1, 6'd9, 32'h0000_0000, 4'b0101);
    run_op(1'b0, 6'd9, '0, '1);
`ifdef SRAM_WMASK_EN
    n_cmp++;
    if (last_rdata !== 32'hFF00_FF00) begin
      n_err++; $display("FAIL wmask_const: got %h want ff00ff00", last_rdata);
    end
`else
    n_cmp++;
    if (last_rdata !== 32'h0000_0000) begin
      n_err++; $display("FAIL fullword_const: got %h want 00000000", last_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_phase();
    test_out_of_range();
    test_back_to_back();
    test_abort(3, 6'd7, 32'h7777_0003, 1'b1);
    test_abort(1, 6'd8, 32'h8888_0001, 1'b0);
    test_wmask();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
